median_sorter: RTL and testbench

- Companion to the window delay line: consumes the newest sample entering the W-sample window and the oldest sample leaving it (the delay-line output).
- Maintains the window contents as an ascending sorted array and emits the running median once per accepted sample.
- Drives the delay line's `flag` (hold) input, so the delay line shifts exactly once per accepted sample.

---
 rtl/median_sorter_pkg.sv | 27 ++
 rtl/median_sorter_if.sv | 23 ++
 rtl/median_sorter_sort_cell.sv | 33 +++
 rtl/median_sorter.sv | 141 ++++++++++++++
 tb/tb_median_sorter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/median_sorter_pkg.sv
// Shared widths, types and encodings for the running-median sorter.
package median_sorter_pkg;

  localparam int unsigned DATA_LENGTH = 8;
  localparam int unsigned W           = 20;
  localparam int unsigned MED_IDX     = W / 2;
  localparam int unsigned IDX_W       = $clog2(W);

  typedef logic [DATA_LENGTH-1:0] data_t;
  typedef logic [IDX_W-1:0]       idx_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEL  = 2'd1,
    S_INS  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Per-entry update selector for one sort cell.
  typedef enum logic [1:0] {
    OP_HOLD    = 2'd0,
    OP_TAKE_HI = 2'd1,
    OP_TAKE_LO = 2'd2,
    OP_NEW     = 2'd3
  } cell_op_t;

endpackage

// File: rtl/median_sorter_if.sv
// Sample-in / median-out handshake bundle between the window delay line side and the sorter.
interface median_sorter_if;
  import median_sorter_pkg::*;

  logic  in_valid;
  logic  in_ready;
  data_t in_new;
  data_t in_old;
  logic  flag;
  data_t median_out;
  logic  out_valid;
  logic  err;

  modport master (
    output in_valid, in_new, in_old,
    input  in_ready, flag, median_out, out_valid, err
  );

  modport slave (
    input  in_valid, in_new, in_old,
    output in_ready, flag, median_out, out_valid, err
  );
endinterface

// File: rtl/median_sorter_sort_cell.sv
// One entry of the sorted window; picks its next value from itself, a neighbour or the new sample.
module median_sorter_sort_cell
  import median_sorter_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  cell_op_t op,
  input  data_t    lo,
  input  data_t    hi,
  input  data_t    new_val,
  output data_t    q
);

  data_t nxt;

  // Next-value select for the delete (shift down) and insert (shift up) passes
  always_comb begin
    nxt = q;
    case (op)
      OP_TAKE_HI: nxt = hi;
      OP_TAKE_LO: nxt = lo;
      OP_NEW:     nxt = new_val;
      default:    nxt = q;
    endcase
  end

  // Entry storage; zero on reset to match the delay line's zeroed taps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= nxt;
  end

endmodule

// File: rtl/median_sorter.sv
// Running median over a W-sample window kept as an ascending sorted array.
module median_sorter
  import median_sorter_pkg::*;
(
  input logic           clk,
  input logic           reset,
  median_sorter_if.slave bus
);

  state_t       state;
  data_t        new_lat;
  data_t        old_lat;
  data_t        median_q;
  logic         ready_q;
  logic         valid_q;
  logic         err_q;
  data_t        sorted [W];
  data_t        lo_v   [W];
  data_t        hi_v   [W];
  cell_op_t     op     [W];
  logic [W-1:0] match;
  logic [W-1:0] del_shift;
  logic         hit;
  idx_t         ins_pos;
  data_t        med_nxt;

  // Which entries equal the sample leaving the window
  always_comb begin
    for (int i = 0; i < int'(W); i++) match[i] = (sorted[i] == old_lat);
  end

  // Lowest match and everything above it shift down; hit flags that a copy exists
  always_comb begin
    del_shift = '0;
    hit       = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      hit          = hit | match[i];
      del_shift[i] = hit;
    end
  end

  // Insert position: entries <= new go below it so new lands after equal values
  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < int'(W) - 1; i++) begin
      if (sorted[i] <= new_lat) ins_pos = ins_pos + idx_t'(1);
    end
  end

  // Per-cell operation for the current pass
  always_comb begin
    for (int i = 0; i < int'(W); i++) begin
      op[i] = OP_HOLD;
      if (state == S_DEL) begin
        if (del_shift[i] && (i < int'(W) - 1)) op[i] = OP_TAKE_HI;
      end else if (state == S_INS) begin
        if (idx_t'(i) == ins_pos)     op[i] = OP_NEW;
        else if (idx_t'(i) > ins_pos) op[i] = OP_TAKE_LO;
      end
    end
  end

  // Median slot value as it will be after the insert pass
  always_comb begin
    case (op[MED_IDX])
      OP_NEW:     med_nxt = new_lat;
      OP_TAKE_LO: med_nxt = sorted[MED_IDX-1];
      default:    med_nxt = sorted[MED_IDX];
    endcase
  end

  for (genvar g = 0; g < int'(W); g++) begin : g_cell
    if (g == 0) begin : g_lo_edge
      assign lo_v[g] = sorted[g];
    end else begin : g_lo_mid
      assign lo_v[g] = sorted[g-1];
    end
    if (g == int'(W) - 1) begin : g_hi_edge
      assign hi_v[g] = sorted[g];
    end else begin : g_hi_mid
      assign hi_v[g] = sorted[g+1];
    end

    median_sorter_sort_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .op      (op[g]),
      .lo      (lo_v[g]),
      .hi      (hi_v[g]),
      .new_val (new_lat),
      .q       (sorted[g])
    );
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      new_lat  <= '0;
      old_lat  <= '0;
      median_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            new_lat <= bus.in_new;
            old_lat <= bus.in_old;
            ready_q <= 1'b0;
            state   <= S_DEL;
          end
        end
        S_DEL: begin
          if (!hit) err_q <= 1'b1;
          state <= S_INS;
        end
        S_INS: begin
          median_q <= med_nxt;
          valid_q  <= 1'b1;
          state    <= S_OUT;
        end
        S_OUT: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delay line shifts only on the accept cycle; held while reset is asserted
  assign bus.flag       = ~(bus.in_valid & ready_q & reset);
  assign bus.in_ready   = ready_q;
  assign bus.median_out = median_q;
  assign bus.out_valid  = valid_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_median_sorter.sv
// Randomised and directed bench for median_sorter with a queue scoreboard.
module tb_median_sorter;
  import median_sorter_pkg::*;

  typedef struct {
    int med;
    int err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  median_sorter_if bus ();

  median_sorter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q [$];
  int   win   [$];   // reference window contents, kept ascending
  int   hist  [$];   // reference delay line, oldest at front
  int   m_err;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    win.delete();
    hist.delete();
    for (int i = 0; i < int'(W); i++) begin
      win.push_back(0);
      hist.push_back(0);
    end
    m_err = 0;
    exp_q.delete();
  endfunction

  // Window as a multiset: drop one copy of old (or the largest if absent), add new, re-sort.
  function automatic void model_accept(int nv, int ov);
    int idx [$];
    exp_t e;
    idx = win.find_first_index(x) with (x == ov);
    if (idx.size() == 0) begin
      m_err = 1;
      void'(win.pop_back());
    end else begin
      win.delete(idx[0]);
    end
    win.push_back(nv);
    win.sort();
    e.med = win[MED_IDX];
    e.err = m_err;
    exp_q.push_back(e);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("median_out", int'(bus.median_out), e.med);
        check("err_at_output", int'(bus.err), e.err);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(int nv, int ov);
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.in_new   = data_t'(nv);
    bus.in_old   = data_t'(ov);
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1;
        check("flag_on_accept", int'(bus.flag), 0);
        model_accept(nv, ov);
      end else begin
        check("flag_while_busy", int'(bus.flag), 1);
      end
    end
    if (!acc) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_dl(int nv);
    int ov;
    ov = hist.pop_front();
    hist.push_back(nv);
    send(nv, ov);
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int nv;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_new   = '0;
    bus.in_old   = '0;
    #1;
    reset = 1'b0;
    model_reset();
    bus.in_valid = 1'b1;
    #1;
    check("flag_in_reset", int'(bus.flag), 1);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_median_out", int'(bus.median_out), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_flag", int'(bus.flag), 1);
    check("rst_err", int'(bus.err), 0);

    // Single accept with cycle-exact handshake timing, valid held through busy cycles
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_new   = 8'd50;
    bus.in_old   = 8'd0;
    void'(hist.pop_front());
    hist.push_back(50);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("c0_flag", int'(bus.flag), 0);
        check("c0_in_ready", int'(bus.in_ready), 1);
        model_accept(50, 0);
      end else begin
        check("busy_in_ready", int'(bus.in_ready), 0);
        check("busy_flag", int'(bus.flag), 1);
        check("out_valid_timing", int'(bus.out_valid), (c == 3) ? 1 : 0);
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();
    check("single_median", int'(bus.median_out), 0);

    // Warm-up: ten accepts of 100 against a zeroed window
    do_reset();
    for (int i = 0; i < 9; i++) send_dl(100);
    drain();
    check("warm9_median", int'(bus.median_out), 0);
    send_dl(100);
    drain();
    check("warm10_median", int'(bus.median_out), 100);

    // Duplicate delete: all-7 window, replace one 7 with a 9
    do_reset();
    for (int i = 0; i < int'(W); i++) send_dl(7);
    send_dl(9);
    drain();
    check("dup_median", int'(bus.median_out), 7);
    check("dup_err", int'(bus.err), 0);

    // Missing old sample: err is sticky through later good accepts
    do_reset();
    send(5, 77);
    drain();
    check("missing_err", int'(bus.err), 1);
    for (int i = 0; i < 3; i++) send_dl(3);
    drain();
    check("missing_err_sticky", int'(bus.err), 1);
    do_reset();
    @(negedge clk);
    check("err_cleared", int'(bus.err), 0);
    @(posedge clk);
    #1;

    // Reset during INS aborts the sample
    bus.in_valid = 1'b1;
    bus.in_new   = 8'd200;
    bus.in_old   = 8'd0;
    @(negedge clk);
    check("abort_accept", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_median", int'(bus.median_out), 0);
    check("abort_in_ready", int'(bus.in_ready), 1);
    check("abort_flag", int'(bus.flag), 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    send_dl(50);
    drain();
    check("post_abort_median", int'(bus.median_out), 0);

    // Random traffic with heavy duplicates, then full range with occasional bogus old
    do_reset();
    for (int i = 0; i < 150; i++) begin
      send_dl(int'($urandom_range(0, 15)));
      n = int'($urandom_range(0, 3));
      if (n > 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 150; i++) begin
      nv = int'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) begin
        void'(hist.pop_front());
        hist.push_back(nv);
        send(nv, int'($urandom_range(0, 255)));
      end else begin
        send_dl(nv);
      end
    end
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
